// File: rtl/rib_arbiter.sv
// rib_arbiter: round-robin owner lock for the shared rib path, plus core stall flag.
// Define RIB_ARB_TIMEOUT_EN to bound each ownership to TIMEOUT_CYCLES granted cycles.
module rib_arbiter #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic       m2_req_i,
  output logic       m0_gnt_o,
  output logic       m1_gnt_o,
  output logic       m2_gnt_o,
  output logic [1:0] grant_o,
  output logic       rib_hold_flag_o,
  output logic       timeout_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [2:0] req;
  logic [2:0] pick;
  logic       busy;
  logic       own_req;
  logic       new_gnt;

  // Returns {valid, index}; search starts just after last, wrapping 2 -> 0.
  function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                         input logic [2:0] r);
    rr_pick = 3'b011;
    unique case (last)
      2'd0: begin
        if (r[1])      rr_pick = 3'b101;
        else if (r[2]) rr_pick = 3'b110;
        else if (r[0]) rr_pick = 3'b100;
      end
      2'd1: begin
        if (r[2])      rr_pick = 3'b110;
        else if (r[0]) rr_pick = 3'b100;
        else if (r[1]) rr_pick = 3'b101;
      end
      default: begin
        if (r[0])      rr_pick = 3'b100;
        else if (r[1]) rr_pick = 3'b101;
        else if (r[2]) rr_pick = 3'b110;
      end
    endcase
  endfunction

  assign req  = {m2_req_i, m1_req_i, m0_req_i};
  assign busy = (state_q == BUSY);
  assign pick = rr_pick(last_q, req);

  always_comb begin
    own_req = 1'b0;
    unique case (owner_q)
      2'd0:    own_req = m0_req_i;
      2'd1:    own_req = m1_req_i;
      2'd2:    own_req = m2_req_i;
      default: own_req = 1'b0;
    endcase
  end

`ifdef RIB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic [2:0] own_mask;
  logic [2:0] pick_x;
  logic       expire;
  logic       timeout_q, timeout_d;

  always_comb begin
    own_mask = 3'b000;
    unique case (owner_q)
      2'd0:    own_mask = 3'b001;
      2'd1:    own_mask = 3'b010;
      2'd2:    own_mask = 3'b100;
      default: own_mask = 3'b000;
    endcase
  end

  assign pick_x    = rr_pick(last_q, req & ~own_mask);
  assign expire    = (cnt_q == TIMEOUT_CYCLES - 8'd1);
  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout_o  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    new_gnt = 1'b0;
`ifdef RIB_ARB_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    if (!busy) begin
      if (pick[2]) begin
        state_d = BUSY;
        owner_d = pick[1:0];
        last_d  = pick[1:0];
        new_gnt = 1'b1;
      end
    end else if (owner_q == 2'b11) begin
      state_d = IDLE;
    end else if (!own_req) begin
      // Releasing owner's req is low, so pick never selects it again here.
      if (pick[2]) begin
        owner_d = pick[1:0];
        last_d  = pick[1:0];
        new_gnt = 1'b1;
      end else begin
        state_d = IDLE;
      end
`ifdef RIB_ARB_TIMEOUT_EN
    end else if (expire) begin
      timeout_d = 1'b1;
      if (pick_x[2]) begin
        owner_d = pick_x[1:0];
        last_d  = pick_x[1:0];
        new_gnt = 1'b1;
      end else begin
        state_d = IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'b00;
      last_q  <= 2'b10;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef RIB_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (new_gnt)
        cnt_q <= 8'd0;
      else if (busy && own_req)
        cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  logic unused_new_gnt;
  assign unused_new_gnt = new_gnt;
`endif

  assign m0_gnt_o = busy & (owner_q == 2'd0) & m0_req_i;
  assign m1_gnt_o = busy & (owner_q == 2'd1) & m1_req_i;
  assign m2_gnt_o = busy & (owner_q == 2'd2) & m2_req_i;
  assign grant_o  = busy ? owner_q : 2'b11;

  assign rib_hold_flag_o = rst_n &
    ((m0_req_i & ~m0_gnt_o) | (busy & (owner_q != 2'b00)));

endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: per-cycle scoreboard of hand-derived expectations.
// Vectors: stim {rst_n,m2,m1,m0}, obs {g2,g1,g0,grant[1:0],hold,timeout}.
module tb_rib_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req_i = 1'b0;
  logic       m1_req_i = 1'b0;
  logic       m2_req_i = 1'b0;
  logic       m0_gnt_o, m1_gnt_o, m2_gnt_o;
  logic [1:0] grant_o;
  logic       rib_hold_flag_o;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  logic [3:0] stim_q[$];
  logic [6:0] exp_q[$];
  logic [6:0] obs;

  assign obs = {m2_gnt_o, m1_gnt_o, m0_gnt_o, grant_o,
                rib_hold_flag_o, timeout_o};

  always #5 clk = ~clk;

  rib_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m0_req_i        (m0_req_i),
    .m1_req_i        (m1_req_i),
    .m2_req_i        (m2_req_i),
    .m0_gnt_o        (m0_gnt_o),
    .m1_gnt_o        (m1_gnt_o),
    .m2_gnt_o        (m2_gnt_o),
    .grant_o         (grant_o),
    .rib_hold_flag_o (rib_hold_flag_o),
    .timeout_o       (timeout_o)
  );

  function automatic void push(input logic [3:0] s, input logic [6:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    logic [3:0] s;
    logic [6:0] e;
    int cyc = 0;
    repeat (3) push(4'b0_111, 7'b000_11_0_0);
    push(4'b1_111, 7'b000_11_1_0);
    push(4'b1_111, 7'b001_00_0_0);
    push(4'b1_000, 7'b000_00_0_0);
    push(4'b1_000, 7'b000_11_0_0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {rst_n, m2_req_i, m1_req_i, m0_req_i} = s;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b want %b", cyc, obs, e);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_fairness();
    logic [3:0] s;
    logic [6:0] e;
    int cyc = 0;
    push(4'b0_000, 7'b000_11_0_0);
    push(4'b1_111, 7'b000_11_1_0);
    repeat (2) push(4'b1_111, 7'b001_00_0_0);
    push(4'b1_110, 7'b000_00_0_0);
    repeat (2) push(4'b1_111, 7'b010_01_1_0);
    push(4'b1_101, 7'b000_01_1_0);
    repeat (2) push(4'b1_111, 7'b100_10_1_0);
    push(4'b1_011, 7'b000_10_1_0);
    repeat (2) push(4'b1_111, 7'b001_00_0_0);
    push(4'b1_000, 7'b000_00_0_0);
    push(4'b1_000, 7'b000_11_0_0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {rst_n, m2_req_i, m1_req_i, m0_req_i} = s;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL fairness cyc %0d: got %b want %b", cyc, obs, e);
      end
      checks++;
      if ($countones(obs[6:4]) > 1) begin
        errors++;
        $display("FAIL onehot cyc %0d: got gnt %b want at most one", cyc,
                 obs[6:4]);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_lone_master();
    logic [3:0] s;
    logic [6:0] e;
    int cyc = 0;
    push(4'b1_010, 7'b000_11_0_0);
    repeat (4) push(4'b1_010, 7'b010_01_1_0);
    push(4'b1_000, 7'b000_01_1_0);
    push(4'b1_000, 7'b000_11_0_0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {rst_n, m2_req_i, m1_req_i, m0_req_i} = s;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL lone cyc %0d: got %b want %b", cyc, obs, e);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_core_stall();
    logic [3:0] s;
    logic [6:0] e;
    int cyc = 0;
    push(4'b1_010, 7'b000_11_0_0);
    push(4'b1_010, 7'b010_01_1_0);
    repeat (2) push(4'b1_011, 7'b010_01_1_0);
    push(4'b1_001, 7'b000_01_1_0);
    push(4'b1_001, 7'b001_00_0_0);
    push(4'b1_000, 7'b000_00_0_0);
    push(4'b1_000, 7'b000_11_0_0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {rst_n, m2_req_i, m1_req_i, m0_req_i} = s;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall cyc %0d: got %b want %b", cyc, obs, e);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_timeout();
    logic [3:0] s;
    logic [6:0] e;
    int cyc = 0;
    push(4'b1_100, 7'b000_11_0_0);
    repeat (4) push(4'b1_101, 7'b100_10_1_0);
`ifdef RIB_ARB_TIMEOUT_EN
    push(4'b1_101, 7'b001_00_0_1);
    push(4'b1_100, 7'b000_00_0_0);
    push(4'b1_100, 7'b100_10_1_0);
    push(4'b1_000, 7'b000_10_1_0);
    push(4'b1_000, 7'b000_11_0_0);
`else
    repeat (3) push(4'b1_101, 7'b100_10_1_0);
    push(4'b1_001, 7'b000_10_1_0);
    push(4'b1_001, 7'b001_00_0_0);
    push(4'b1_000, 7'b000_00_0_0);
    push(4'b1_000, 7'b000_11_0_0);
`endif
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {rst_n, m2_req_i, m1_req_i, m0_req_i} = s;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout cyc %0d: got %b want %b", cyc, obs, e);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] s;
    logic [6:0] e;
    int cyc = 0;
    push(4'b1_001, 7'b000_11_1_0);
    push(4'b1_001, 7'b001_00_0_0);
    push(4'b0_001, 7'b001_00_0_0);
    push(4'b1_110, 7'b000_11_0_0);
    push(4'b1_110, 7'b010_01_1_0);
    push(4'b1_000, 7'b000_01_1_0);
    push(4'b1_000, 7'b000_11_0_0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      {rst_n, m2_req_i, m1_req_i, m0_req_i} = s;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL midreset cyc %0d: got %b want %b", cyc, obs, e);
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fairness();
    test_lone_master();
    test_core_stall();
    test_timeout();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
